branch_resolver: RTL and testbench
==================================

# branch_resolver

ID-stage branch resolution unit for the pipelined MIPS core. It consumes the `equal`/`bge` compare flags produced on forwarded ID-stage operands and turns them into a registered PC redirect for the IF stage. It stalls ID while operands are not yet forwardable and holds the redirect until fetch accepts it. Delayed-branch semantics apply: the delay-slot instruction is never annulled by this block.

## Interface
- `BR_W`, 3: width of the branch-type code (encodings in the shared package).
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `id_valid` in 1: the ID-stage instruction is valid.
- `br_type` in BR_W: one of NONE=0, BEQ=1, BNE=2, BGEZ=3, BLTZ=4, J=5, JR=6.
- `pc_id` in 32: PC of the branch/jump in ID.
- `imm16` in 16: branch offset in words.
- `jidx` in 26: J-format index.
- `rs_val` in 32: forwarded rs value; the JR target.
- `equal` in 1: comparator flag, rs == rt.
- `bge` in 1: comparator flag, rs[31] == 0.
- `opnd_ready` in 1: forwarding unit reports rs/rt final this cycle.
- `flush` in 1: exception/eret flush; highest priority.
- `redirect_ready` in 1: IF accepts the redirect this cycle.
- `redirect_valid` out 1: the redirect PC is valid.
- `redirect_pc` out 32: target PC.
- `id_stall` out 1: hold ID and IF.

## Operation
- States: IDLE, WAIT_OPND, REDIRECT.
- Evaluation cycle: IDLE, `id_valid`=1, `br_type`≠NONE and `opnd_ready`=1. The decision is registered.
  - Taken: go to REDIRECT and latch the target.
  - Not taken: stay in IDLE with no stall.
- Branch seen with `opnd_ready`=0: go to WAIT_OPND and assert `id_stall`. Evaluate on the first cycle `opnd_ready`=1, using the flags of that cycle. The ID inputs are held by the stall.
- Taken conditions:
  - BEQ: `equal`.
  - BNE: `!equal`.
  - BGEZ: `bge`.
  - BLTZ: `!bge`.
  - J and JR: always.
- Targets, with mod-2^32 wrap and no overflow detection:
  - Branch: `pc_id`+4+(sign-extended `imm16`<<2).
  - J: {(`pc_id`+4)[31:28], `jidx`, 2'b00}.
  - JR: `rs_val` as given; the low bits are not checked.
- J needs no operands and is evaluated even when `opnd_ready`=0.
- REDIRECT: `redirect_valid`=1 and `redirect_pc` is stable. Leave to IDLE on `redirect_valid`&&`redirect_ready`.
- `id_valid`/`br_type` are ignored outside IDLE. ID is stalled then, so no branch is lost.
- `flush` in any state: go to IDLE next cycle and drop any pending redirect. A flush in the evaluation cycle suppresses the decision.
- Unknown `br_type` codes 7+ are treated as NONE.

## Timing
- Reset values: `redirect_valid`=0, `redirect_pc`=0, `id_stall`=0, state IDLE, statistics counters 0.
- `id_stall` is combinational: (state==WAIT_OPND && !`opnd_ready`) || (state==IDLE && `id_valid` && branch && !`opnd_ready` && type≠J) || (state==REDIRECT && !`redirect_ready`). It is forced to 0 while `flush`=1.
- Latency: `redirect_valid` rises 1 cycle after the evaluation cycle.
- Minimum taken-branch occupancy: 2 cycles (evaluate, then redirect accepted).
- Back-to-back: a new branch can be evaluated in the cycle after the redirect is accepted.

## Configuration
- `BRU_STATS_EN` defined adds two outputs:
  - `br_count` out 32: evaluated branches and jumps.
  - `taken_count` out 32: taken ones.
- Both counters wrap at 2^32, increment in the evaluation cycle, do not count flushed evaluations, and reset to 0.
- `BRU_STATS_EN` undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `bru_pkg` holds:
  - the `br_type` localparams NONE..JR;
  - the state encoding IDLE/WAIT_OPND/REDIRECT;
  - the constant PC_STEP=4.
- Sub-module `branch_target_calc`: combinational; computes the branch, J and JR targets and the taken bit from type and flags. The FSM and registers stay in `branch_resolver`.

## Test plan
- BEQ, `pc_id`=0x00003000, `imm16`=0x0003, `equal`=1, `opnd_ready`=1, `redirect_ready`=1 -> next cycle `redirect_valid`=1, `redirect_pc`=0x00003010; no stall.
- BNE, `equal`=1 -> no redirect, `id_stall`=0. BLTZ with `bge`=0, `imm16`=0xFFFF, `pc_id`=0x00003004 -> `redirect_pc`=0x00003004.
- BGEZ with `opnd_ready` low for 3 cycles -> `id_stall`=1 for 3 cycles, then the redirect is asserted one cycle after ready rises.
- JR with `rs_val`=0x00400020 and `redirect_ready` low for 2 cycles -> `redirect_pc` held stable and `id_stall`=1, then the redirect clears after the ready cycle.
- `flush` asserted in REDIRECT, and separately async `reset` dropped mid-WAIT_OPND -> IDLE, `redirect_valid`=0; with `BRU_STATS_EN` the counters read 0 after reset.
- `BRU_STATS_EN`: 5 branches, 3 taken -> `br_count`=5, `taken_count`=3.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared encodings for the ID-stage branch resolver: branch-type codes, FSM states, PC step.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bru_pkg;

  localparam int unsigned BR_TYPE_W = 3;

  localparam logic [BR_TYPE_W-1:0] BR_NONE = 3'd0;
  localparam logic [BR_TYPE_W-1:0] BR_BEQ  = 3'd1;
  localparam logic [BR_TYPE_W-1:0] BR_BNE  = 3'd2;
  localparam logic [BR_TYPE_W-1:0] BR_BGEZ = 3'd3;
  localparam logic [BR_TYPE_W-1:0] BR_BLTZ = 3'd4;
  localparam logic [BR_TYPE_W-1:0] BR_J    = 3'd5;
  localparam logic [BR_TYPE_W-1:0] BR_JR   = 3'd6;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    REDIRECT  = 2'd2
  } bru_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target/taken computation for branches, J and JR.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; results are sampled by the resolver FSM.
module branch_target_calc
  import bru_pkg::*;
(
  input  logic [BR_TYPE_W-1:0] br_type,
  input  logic [31:0]          pc_id,
  input  logic [15:0]          imm16,
  input  logic [25:0]          jidx,
  input  logic [31:0]          rs_val,
  input  logic                 equal,
  input  logic                 bge,
  output logic                 is_branch,
  output logic                 taken,
  output logic [31:0]          target
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;

  assign pc_plus4  = pc_id + PC_STEP;
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  // Decode type into taken bit and the matching target; codes 7+ behave as NONE.
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    target    = pc_plus4 + br_offset;
    case (br_type)
      BR_BEQ:  begin is_branch = 1'b1; taken = equal;  end
      BR_BNE:  begin is_branch = 1'b1; taken = !equal; end
      BR_BGEZ: begin is_branch = 1'b1; taken = bge;    end
      BR_BLTZ: begin is_branch = 1'b1; taken = !bge;   end
      BR_J: begin
        is_branch = 1'b1;
        taken     = 1'b1;
        target    = {pc_plus4[31:28], jidx, 2'b00};
      end
      BR_JR: begin
        is_branch = 1'b1;
        taken     = 1'b1;
        target    = rs_val;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolution: registered PC redirect to IF, ID stall until operands are final.
// Latency: redirect_valid rises 1 cycle after the evaluation cycle; flush drops it next cycle.
// Backpressure: redirect held stable until redirect_ready; id_stall asserted meanwhile. BRU_STATS_EN adds counters.
module branch_resolver
  import bru_pkg::*;
#(
  parameter int unsigned BR_W = BR_TYPE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [BR_W-1:0] br_type,
  input  logic [31:0]     pc_id,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx,
  input  logic [31:0]     rs_val,
  input  logic            equal,
  input  logic            bge,
  input  logic            opnd_ready,
  input  logic            flush,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic            id_stall
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
`endif
);

  bru_state_t  state, state_nxt;
  logic        is_branch, taken;
  logic [31:0] target;
  logic        is_j;
  logic        eval;

  branch_target_calc u_calc (
    .br_type   (br_type),
    .pc_id     (pc_id),
    .imm16     (imm16),
    .jidx      (jidx),
    .rs_val    (rs_val),
    .equal     (equal),
    .bge       (bge),
    .is_branch (is_branch),
    .taken     (taken),
    .target    (target)
  );

  assign is_j           = (br_type == BR_J);
  assign redirect_valid = (state == REDIRECT);

  // Next state, evaluation strobe and ID stall; flush overrides everything.
  always_comb begin
    state_nxt = state;
    eval      = 1'b0;
    id_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (id_valid && is_branch) begin
          if (opnd_ready || is_j) begin
            eval      = 1'b1;
            state_nxt = taken ? REDIRECT : IDLE;
          end else begin
            id_stall  = 1'b1;
            state_nxt = WAIT_OPND;
          end
        end
      end
      WAIT_OPND: begin
        // ID inputs are frozen by the stall, so the held branch is evaluated here.
        if (opnd_ready) begin
          eval      = 1'b1;
          state_nxt = taken ? REDIRECT : IDLE;
        end else begin
          id_stall = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_nxt = IDLE;
        else                id_stall  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      eval      = 1'b0;
      id_stall  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the target on a taken evaluation; it stays stable through REDIRECT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             redirect_pc <= 32'd0;
    else if (eval && taken) redirect_pc <= target;
  end

`ifdef BRU_STATS_EN
  // Statistics: evaluated and taken branches, flushed evaluations excluded by eval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count    <= 32'd0;
      taken_count <= 32'd0;
    end else if (eval) begin
      br_count <= br_count + 32'd1;
      if (taken) taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with an expected-redirect scoreboard.
// Latency: checks redirect one cycle after evaluation; stall checked mid-cycle.
// Backpressure: exercises redirect_ready low and flush while redirecting.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [2:0]  br_type;
  logic [31:0] pc_id;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] rs_val;
  logic        equal;
  logic        bge;
  logic        opnd_ready;
  logic        flush;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
`ifdef BRU_STATS_EN
  logic [31:0] br_count;
  logic [31:0] taken_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .br_type        (br_type),
    .pc_id          (pc_id),
    .imm16          (imm16),
    .jidx           (jidx),
    .rs_val         (rs_val),
    .equal          (equal),
    .bge            (bge),
    .opnd_ready     (opnd_ready),
    .flush          (flush),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall)
`ifdef BRU_STATS_EN
    ,
    .br_count       (br_count),
    .taken_count    (taken_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop on accepted redirect, check stability while held.
  always @(negedge clk) begin
    if (reset === 1'b1 && redirect_valid === 1'b1) begin
      if (redirect_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_redirect: got pc 0x%08h with no redirect expected", redirect_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checks--;
          chk("redirect_pc", redirect_pc, e);
        end
      end else if (exp_q.size() != 0) begin
        chk("redirect_pc_held", redirect_pc, exp_q[0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] im,
                       input logic [25:0] ji, input logic [31:0] rs, input logic eq,
                       input logic ge, input logic rdy);
    id_valid   = 1'b1;
    br_type    = t;
    pc_id      = pc;
    imm16      = im;
    jidx       = ji;
    rs_val     = rs;
    equal      = eq;
    bge        = ge;
    opnd_ready = rdy;
  endtask

  // One-cycle branch issue followed by two idle cycles (room for redirect + accept).
  task automatic issue(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] im,
                       input logic eq, input logic ge, input logic tk, input logic [31:0] tgt);
    cyc();
    drive(t, pc, im, 26'h0, 32'h0, eq, ge, 1'b1);
    if (tk) exp_q.push_back(tgt);
    cyc();
    id_valid = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    id_valid = 1'b0; br_type = 3'd0; pc_id = 32'h0; imm16 = 16'h0; jidx = 26'h0;
    rs_val = 32'h0; equal = 1'b0; bge = 1'b0; opnd_ready = 1'b1; flush = 1'b0;
    redirect_ready = 1'b1;
    #12;
    chk("reset_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);
    chk("reset_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    reset = 1'b1;

    // BEQ taken: 0x3000+4+12
    cyc();
    drive(3'd1, 32'h0000_3000, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_3010);
    mid();
    chk("beq_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    id_valid = 1'b0;
    mid();
    chk("beq_valid", {31'd0, redirect_valid}, 32'd1);
    cyc();
    mid();
    chk("beq_valid_clear", {31'd0, redirect_valid}, 32'd0);

    // BNE with equal=1: not taken
    cyc();
    drive(3'd2, 32'h0000_3000, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    mid();
    chk("bne_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    id_valid = 1'b0;
    mid();
    chk("bne_no_redirect", {31'd0, redirect_valid}, 32'd0);

    // BLTZ backward offset -1 word: 0x3008-4
    cyc();
    drive(3'd4, 32'h0000_3004, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_3004);
    cyc();
    id_valid = 1'b0;
    mid();
    chk("bltz_valid", {31'd0, redirect_valid}, 32'd1);
    cyc();

    // BGEZ with operands late by 3 cycles: 0x3104+0x40
    cyc();
    drive(3'd3, 32'h0000_3100, 16'h0010, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("bgez_stall_%0d", i), {31'd0, id_stall}, 32'd1);
      chk($sformatf("bgez_wait_novalid_%0d", i), {31'd0, redirect_valid}, 32'd0);
      cyc();
    end
    opnd_ready = 1'b1;
    exp_q.push_back(32'h0000_3144);
    mid();
    chk("bgez_ready_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    id_valid = 1'b0;
    mid();
    chk("bgez_valid", {31'd0, redirect_valid}, 32'd1);
    cyc();

    // JR with IF backpressure for 2 cycles
    cyc();
    drive(3'd6, 32'h0000_3200, 16'h0000, 26'h0, 32'h0040_0020, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'h0040_0020);
    cyc();
    id_valid = 1'b0;
    redirect_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk($sformatf("jr_hold_stall_%0d", i), {31'd0, id_stall}, 32'd1);
      chk($sformatf("jr_hold_valid_%0d", i), {31'd0, redirect_valid}, 32'd1);
      cyc();
    end
    redirect_ready = 1'b1;
    mid();
    chk("jr_accept_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    mid();
    chk("jr_cleared", {31'd0, redirect_valid}, 32'd0);

    // J evaluated without operands: {0x1, 0x123456, 00}
    cyc();
    drive(3'd5, 32'h1000_0000, 16'h0000, 26'h0123456, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h1048_D158);
    mid();
    chk("j_no_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    id_valid = 1'b0;
    opnd_ready = 1'b1;
    mid();
    chk("j_valid", {31'd0, redirect_valid}, 32'd1);
    cyc();

    // Flush while in REDIRECT drops the redirect
    cyc();
    drive(3'd1, 32'h0000_2000, 16'h0001, 26'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_2008);
    redirect_ready = 1'b0;
    cyc();
    id_valid = 1'b0;
    flush = 1'b1;
    mid();
    chk("flush_stall_forced", {31'd0, id_stall}, 32'd0);
    cyc();
    flush = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    redirect_ready = 1'b1;
    mid();
    chk("flush_dropped", {31'd0, redirect_valid}, 32'd0);

    // Flush in the evaluation cycle suppresses the decision
    cyc();
    drive(3'd1, 32'h0000_2000, 16'h0001, 26'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    cyc();
    id_valid = 1'b0;
    flush = 1'b0;
    mid();
    chk("flush_eval_suppressed", {31'd0, redirect_valid}, 32'd0);

    // Unknown type 7 behaves as NONE
    cyc();
    drive(3'd7, 32'h0000_2000, 16'h0001, 26'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    mid();
    chk("type7_no_stall", {31'd0, id_stall}, 32'd0);
    cyc();
    id_valid = 1'b0;
    opnd_ready = 1'b1;
    mid();
    chk("type7_no_redirect", {31'd0, redirect_valid}, 32'd0);

    // Async reset in the middle of WAIT_OPND
    cyc();
    drive(3'd3, 32'h0000_3100, 16'h0010, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc();
    #2;
    id_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("arst_stall", {31'd0, id_stall}, 32'd0);
`ifdef BRU_STATS_EN
    chk("arst_br_count", br_count, 32'd0);
    chk("arst_taken_count", taken_count, 32'd0);
`endif
    opnd_ready = 1'b1;
    cyc();
    reset = 1'b1;
    mid();
    chk("post_reset_idle", {31'd0, redirect_valid}, 32'd0);

    // Five branches, three taken
    issue(3'd1, 32'h0000_4000, 16'h0002, 1'b1, 1'b0, 1'b1, 32'h0000_400C);
    issue(3'd2, 32'h0000_4010, 16'h0002, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(3'd3, 32'h0000_4020, 16'hFFFE, 1'b0, 1'b1, 1'b1, 32'h0000_401C);
    issue(3'd4, 32'h0000_4030, 16'h0004, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    drive(3'd5, 32'h2000_0000, 16'h0000, 26'h0000040, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'h2000_0100);
    cyc();
    id_valid = 1'b0;
    cyc();
    mid();
`ifdef BRU_STATS_EN
    chk("br_count", br_count, 32'd5);
    chk("taken_count", taken_count, 32'd3);
`endif
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
